// File: rtl/mult.sv
// ---------------------------------------------------------------------------
// mult -- sequential unsigned shift-and-add multiplier
//
// Processes one multiplier bit per clock and produces an exact 2*WIDTH-bit
// product. It uses the same start/ready/done handshake as the sequential
// divider, so measurement logic can drive both blocks with one control
// sequence.
//
// Parameters:
//   WIDTH            operand width (default 32); the product is 2*WIDTH bits
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_start          start request, sampled only while idle
//   i_multiplicand   unsigned operand A, captured with the accepted start
//   i_multiplier     unsigned operand B, captured with the accepted start
//   o_ready          high while idle (registered)
//   o_done           one-clock pulse when o_product is valid (registered)
//   o_product        A*B, held until the next accepted start clears it
//
// Configuration macro:
//   MULT_EARLY_TERM_EN  when defined, OP ends as soon as no set multiplier
//                       bits remain. OP then takes max(1, msb_index(B)+1)
//                       clocks. When undefined, OP always takes exactly
//                       WIDTH clocks, which gives deterministic latency.
// ---------------------------------------------------------------------------
module mult #(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  output logic                 o_ready,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [PW-1:0]      mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      prod_q,   prod_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               ready_q,  ready_d;
  logic               done_q,   done_d;

  logic               op_last_s;

  // Decide whether the current OP clock is the final one.
`ifdef MULT_EARLY_TERM_EN
  // Once the bits that remain after this shift are all zero, later clocks
  // could not add anything, so the operation stops early.
  always_comb begin
    op_last_s = (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}}) || (cnt_q == CNT_ONE);
  end
`else
  always_comb begin
    op_last_s = (cnt_q == CNT_ONE);
  end
`endif

  // Next-state and datapath computation for the IDLE/OP/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          // Accepting a start clears the previous product.
          mcand_d  = {{WIDTH{1'b0}}, i_multiplicand};
          mplier_d = i_multiplier;
          prod_d   = {PW{1'b0}};
          cnt_d    = CNT_LOAD;
          state_d  = S_OP;
          ready_d  = 1'b0;
        end else begin
          state_d  = S_IDLE;
          ready_d  = 1'b1;
        end
      end

      S_OP: begin
        // The adder is full product width, so it cannot overflow.
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end else begin
          prod_d = prod_q;
        end
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CNT_ONE;
        ready_d  = 1'b0;
        if (op_last_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_OP;
          done_d  = 1'b0;
        end
      end

      S_DONE: begin
        // i_start is not sampled here; a start held high is taken in IDLE.
        state_d = S_IDLE;
        ready_d = 1'b1;
        done_d  = 1'b0;
      end

      default: begin
        state_d  = S_IDLE;
        mcand_d  = {PW{1'b0}};
        mplier_d = {WIDTH{1'b0}};
        prod_d   = {PW{1'b0}};
        cnt_d    = {CNT_W{1'b0}};
        ready_d  = 1'b1;
        done_d   = 1'b0;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= {PW{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      prod_q   <= {PW{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_done    = done_q;
  assign o_product = prod_q;

endmodule

// File: tb/tb_mult.sv
// ---------------------------------------------------------------------------
// tb_mult -- directed self-checking bench for mult (WIDTH = 32).
// Expected products are hand-computed constants. The expected latency is
// derived from B according to the build configuration.
// ---------------------------------------------------------------------------
module tb_mult;

  localparam int W = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic            ready;
  logic            done;
  logic [2*W-1:0]  product;

  int n_checks;
  int n_fail;

  mult #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_multiplicand (mcand),
    .i_multiplier   (mplier),
    .o_ready        (ready),
    .o_done         (done),
    .o_product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
    int n;
`ifdef MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < W; i++) begin
      if (b[i]) n = i + 1;
    end
`else
    n = W;
`endif
    return n;
  endfunction

  // Start one operation from IDLE. Then check latency, product, a
  // single-cycle done pulse and that the result is held afterwards.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp);
    int cyc;
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_ready_low"}, 64'(ready), 64'd0);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat(b)));
    check({tag, "_product"}, product, exp);
    @(posedge clk); #1;
    check({tag, "_done_1clk"}, 64'(done), 64'd0);
    check({tag, "_ready_back"}, 64'(ready), 64'd1);
    check({tag, "_held"}, product, exp);
  endtask

  initial begin
    int cyc;
    int dones;
    int t;
    int first;
    int second;
    logic [63:0] got;

    n_checks = 0;
    n_fail   = 0;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; mcand = '0; mplier = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op("unit_b",  32'd1_000_000_000, 32'd1,          64'd1_000_000_000);
    run_op("max_ops", 32'hFFFF_FFFF,     32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
    run_op("zero_a",  32'd0,             32'd12345,      64'd0);
    run_op("zero_b",  32'd6767,          32'd0,          64'd0);

    // A second start during OP must be ignored and must not be queued.
    @(negedge clk);
    start = 1'b1; mcand = 32'd1_000_000; mplier = 32'd999;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; dones = 0; got = '0;
    while (!ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 9) begin
        start = 1'b1; mcand = 32'd5; mplier = 32'd5;
      end
      if (cyc == 10) start = 1'b0;
      if (done) begin
        dones++;
        got = product;
      end
    end
    check("ignore_product", got, 64'd999_000_000);
    check("ignore_done_count", 64'(dones), 64'd1);
    @(posedge clk); #1;
    check("ignore_no_restart", 64'(ready), 64'd1);
    check("ignore_held", product, 64'd999_000_000);
    run_op("restart", 32'd5, 32'd5, 64'd25);

    // With start held high, a new product arrives every lat+2 clocks.
    @(negedge clk);
    start = 1'b1; mcand = 32'd3; mplier = 32'd7;
    t = 0; first = -1; second = -1;
    while (second < 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
      if (done) begin
        if (first < 0) first = t;
        else second = t;
      end
    end
    start = 1'b0;
    check("held_spacing", 64'(second - first), 64'(exp_lat(32'd7) + 2));
    check("held_product", product, 64'd21);
    repeat (2) @(posedge clk);
    #1;
    check("held_idle", 64'(ready), 64'd1);

    // An asynchronous reset in mid-OP aborts the operation.
    @(negedge clk);
    start = 1'b1; mcand = 32'd676767; mplier = 32'd1477;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run_op("post_rst", 32'd676767, 32'd1477, 64'd999_584_859);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
